// File: rtl/seq_capture_arbiter.sv
// rtl/seq_capture_arbiter.sv - per-channel 1110 detectors with round-robin capture drain
module seq_capture_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            d_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            clr_ovf,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic [NUM_CH-1:0]            det,
  output logic [NUM_CH-1:0]            ovf
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_t;

  det_state_t            r_state     [NUM_CH];
  det_state_t            w_state_nxt [NUM_CH];
  logic [DATA_WIDTH-1:0] r_hold      [NUM_CH];
  logic [NUM_CH-1:0]     r_pending;
  logic [NUM_CH-1:0]     r_ovf;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]       r_out_ch;
  logic [CH_W-1:0]       r_rr_ptr;

  logic [NUM_CH-1:0]     w_det;
  logic                  w_slot_free;
  logic                  w_grant;
  logic [CH_W-1:0]       w_gnt_idx;
  logic [CH_W-1:0]       w_cand;
  logic [CH_W-1:0]       w_rr_nxt;
  logic [NUM_CH-1:0]     w_gnt_vec;
  logic [NUM_CH-1:0]     w_drop;
  logic [NUM_CH-1:0]     w_load;

  // Detector next-state: overlapping 1110 search, a 1 after detection restarts at S1
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = S0;
      case (r_state[i])
        S0:      w_state_nxt[i] = d_in[i] ? S1 : S0;
        S1:      w_state_nxt[i] = d_in[i] ? S2 : S0;
        S2:      w_state_nxt[i] = d_in[i] ? S3 : S0;
        S3:      w_state_nxt[i] = d_in[i] ? S3 : S4;
        S4:      w_state_nxt[i] = d_in[i] ? S1 : S0;
        default: w_state_nxt[i] = S0;
      endcase
      w_det[i] = (r_state[i] == S4);
    end
  end

  // Detector state registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) r_state[i] <= S0;
      else       r_state[i] <= w_state_nxt[i];
    end
  end

  // Round-robin search from r_rr_ptr; a grant also frees that channel for a same-edge capture
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_grant     = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_grant && r_pending[w_cand]) begin
        w_grant   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_grant  = w_grant && w_slot_free;
    w_rr_nxt = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
    for (int i = 0; i < NUM_CH; i++) begin
      w_gnt_vec[i] = w_grant && (w_gnt_idx == CH_W'(i));
      w_drop[i]    = w_det[i] && r_pending[i] && !w_gnt_vec[i];
      w_load[i]    = w_det[i] && !w_drop[i];
    end
  end

  // Holding registers, pending flags and sticky overflow (a drop beats a clear)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        r_hold[i]    <= '0;
        r_pending[i] <= 1'b0;
        r_ovf[i]     <= 1'b0;
      end else begin
        if (w_load[i]) begin
          r_hold[i]    <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
          r_pending[i] <= 1'b1;
        end else if (w_gnt_vec[i]) begin
          r_pending[i] <= 1'b0;
        end
        if (w_drop[i])       r_ovf[i] <= 1'b1;
        else if (clr_ovf[i]) r_ovf[i] <= 1'b0;
      end
    end
  end

  // Output slot: load on grant, empty when accepted with nothing pending, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_hold[w_gnt_idx];
      r_out_ch    <= w_gnt_idx;
      r_rr_ptr    <= w_rr_nxt;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign det       = w_det;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_capture_arbiter.sv
// tb/tb_seq_capture_arbiter.sv - vectors, corner sequences and random run against a reference model
module tb_seq_capture_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    d_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]    clr_ovf = '0;
  logic            out_ready = 1'b1;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic [N-1:0]    det;
  logic [N-1:0]    ovf;

  seq_capture_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .data_in   (data_in),
    .clr_ovf   (clr_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .det       (det),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: detector as a run length of ones, arbiter as a modular search
  int            m_run   [N];
  bit            m_det   [N];
  bit            m_pend  [N];
  logic [DW-1:0] m_hold  [N];
  bit            m_ovf   [N];
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_rr;

  int            q_ch[$];
  logic [DW-1:0] q_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  g;
    bit  free;
    bit  drop;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_det[i] = 0; m_pend[i] = 0; m_hold[i] = '0; m_ovf[i] = 0;
      end
      m_valid = 0; m_data = '0; m_ch = 0; m_rr = 0;
      return;
    end
    free = !m_valid || out_ready;
    g = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) begin
      m_valid = 1; m_data = m_hold[g]; m_ch = g; m_pend[g] = 0; m_rr = (g + 1) % N;
    end else if (free) begin
      m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      drop = m_det[i] && m_pend[i] && (g != i);
      if (m_det[i] && !drop) begin
        m_hold[i] = data_in[i*DW +: DW];
        m_pend[i] = 1;
      end
      if (drop)            m_ovf[i] = 1;
      else if (clr_ovf[i]) m_ovf[i] = 0;
      m_det[i] = !d_in[i] && (m_run[i] >= 3);
      m_run[i] = d_in[i] ? ((m_run[i] < 3) ? m_run[i] + 1 : 3) : 0;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] e_det;
    logic [N-1:0] e_ovf;
    for (int i = 0; i < N; i++) begin
      e_det[i] = m_det[i];
      e_ovf[i] = m_ovf[i];
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_ch", 32'(out_ch), m_ch);
    chk("det", 32'(det), 32'(e_det));
    chk("ovf", 32'(ovf), 32'(e_ovf));
  endtask

  task automatic tick();
    if (out_valid && out_ready) begin
      q_ch.push_back(int'(out_ch));
      q_data.push_back(out_data);
    end
    model_update();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    d_in = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; d_in = '0; clr_ovf = '0;
    tick();
    reset = 1'b0;
    q_ch.delete();
    q_data.delete();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  d;
    logic [31:0] w0;
    logic [3:0]  exp_det;
    logic        exp_v;
    logic [1:0]  exp_ch;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            pulses;
    int            exp_ord[9];
    logic [31:0]   words[3];
    bit            phase_lo;

    // single ch0 capture: det for one cycle, data sampled at E1, output at E2
    tbl[0] = '{1'b1, 4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 32'h0};
    tbl[1] = '{1'b0, 4'h1, 32'h0,        4'h0, 1'b0, 2'd0, 32'h0};
    tbl[2] = '{1'b0, 4'h1, 32'h0,        4'h0, 1'b0, 2'd0, 32'h0};
    tbl[3] = '{1'b0, 4'h1, 32'h0,        4'h0, 1'b0, 2'd0, 32'h0};
    tbl[4] = '{1'b0, 4'h0, 32'h0,        4'h1, 1'b0, 2'd0, 32'h0};
    tbl[5] = '{1'b0, 4'h0, 32'hDEADBEEF, 4'h0, 1'b0, 2'd0, 32'h0};
    tbl[6] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 2'd0, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 32'hDEADBEEF};

    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      reset = tbl[r].rst;
      d_in = tbl[r].d;
      data_in = '0;
      data_in[31:0] = tbl[r].w0;
      tick();
      chk($sformatf("vec%0d_det", r), 32'(det), 32'(tbl[r].exp_det));
      chk($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(tbl[r].exp_v));
      chk($sformatf("vec%0d_ch", r), 32'(out_ch), 32'(tbl[r].exp_ch));
      chk($sformatf("vec%0d_data", r), out_data, tbl[r].exp_data);
      chk($sformatf("vec%0d_ovf", r), 32'(ovf), 32'h0);
    end
    reset = 1'b0;

    // overlapping stream on ch1
    do_reset();
    pulses = 0;
    begin
      logic [9:0] s;
      s = 10'b1111101110;
      for (int t = 0; t < 10; t++) begin
        d_in = {2'b00, s[9-t], 1'b0};
        data_in[1*DW +: DW] = 32'h1000 + t;
        tick();
        if (det[1]) pulses++;
      end
    end
    for (int t = 0; t < 6; t++) begin
      d_in = '0;
      tick();
      if (det[1]) pulses++;
    end
    chk("overlap_det_pulses", pulses, 2);
    chk("overlap_captures", q_ch.size(), 2);
    chk("overlap_ovf", 32'(ovf), 32'h0);

    // simultaneous detects, then a lone ch1 to move the pointer to 2, then simultaneous again
    do_reset();
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 32'h11111111 * (i + 1);
    d_in = 4'hF; tick(); tick(); tick();
    d_in = 4'h0; tick();
    idle(8);
    d_in = 4'h2; tick(); tick(); tick();
    d_in = 4'h0; tick();
    idle(6);
    d_in = 4'hF; tick(); tick(); tick();
    d_in = 4'h0; tick();
    idle(8);
    exp_ord = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
    chk("rr_count", q_ch.size(), 9);
    for (int k = 0; k < 9 && k < q_ch.size(); k++) begin
      chk($sformatf("rr_order%0d", k), q_ch[k], exp_ord[k]);
      chk($sformatf("rr_data%0d", k), q_data[k], 32'h11111111 * (exp_ord[k] + 1));
    end

    // stalled output: third ch2 word is dropped, first word held stable
    do_reset();
    words = '{32'hA, 32'hB, 32'hC};
    out_ready = 1'b0;
    for (int t = 0; t < 16; t++) begin
      d_in = '0;
      if (t < 12) d_in[2] = ((t % 4) != 3);
      data_in[2*DW +: DW] = words[(t == 0) ? 0 : ((t - 1) / 4 > 2 ? 2 : (t - 1) / 4)];
      tick();
      if (t >= 6) chk("bp_hold_data", out_data, 32'hA);
    end
    chk("bp_no_transfer", q_ch.size(), 0);
    chk("bp_ovf", 32'(ovf), 32'h4);
    out_ready = 1'b1;
    idle(5);
    chk("bp_out_count", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      chk("bp_out0", q_data[0], 32'hA);
      chk("bp_out1", q_data[1], 32'hB);
    end
    clr_ovf = 4'h4; tick();
    clr_ovf = 4'h0; tick();
    chk("bp_ovf_cleared", 32'(ovf), 32'h0);

    // ch3 pending granted on the same edge as a new ch3 detect
    do_reset();
    words = '{32'h3A, 32'h3B, 32'h3C};
    out_ready = 1'b0;
    for (int t = 0; t < 13; t++) begin
      d_in = '0;
      if (t < 12) d_in[3] = ((t % 4) != 3);
      if (t == 12) out_ready = 1'b1;
      data_in[3*DW +: DW] = words[(t == 0) ? 0 : ((t - 1) / 4 > 2 ? 2 : (t - 1) / 4)];
      tick();
    end
    idle(5);
    chk("redet_ovf", 32'(ovf), 32'h0);
    chk("redet_count", q_data.size(), 3);
    for (int k = 0; k < 3 && k < q_data.size(); k++)
      chk($sformatf("redet_out%0d", k), q_data[k], words[k]);

    // reset while a word is on the output and two channels are pending
    do_reset();
    out_ready = 1'b0;
    d_in = 4'h7; tick(); tick(); tick();
    d_in = 4'h0; tick();
    idle(2);
    chk("rst_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1; tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_det", 32'(det), 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    q_ch.delete();
    idle(6);
    chk("rst_no_stale", q_ch.size(), 0);

    // random traffic with alternating ready-heavy and stall-heavy phases
    do_reset();
    phase_lo = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t % 60 == 0) phase_lo = !phase_lo;
      for (int i = 0; i < N; i++) begin
        d_in[i] = ($urandom_range(0, 3) != 0);
        clr_ovf[i] = ($urandom_range(0, 15) == 0);
        data_in[i*DW +: DW] = $urandom;
      end
      out_ready = phase_lo ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
